// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, RV32I load/store funct3 encodings and
// address-field width helpers for the data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REFILL_REQ  = 2'd1,
        REFILL_WAIT = 2'd2
    } state_t;

    // Load widths
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    // Store widths
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Word-within-line field width
    function automatic int offsetBits(input int wordsPerLine);
        return $clog2(wordsPerLine);
    endfunction

    // Set-index field width
    function automatic int indexBits(input int sets);
        return $clog2(sets);
    endfunction

    // Tag is everything above byte, word and index fields
    function automatic int tagBits(input int sets, input int wordsPerLine);
        return 32 - 2 - offsetBits(wordsPerLine) - indexBits(sets);
    endfunction

endpackage

// File: rtl/dcache_align.sv
// dcache_align: combinational byte-lane logic shared by the load read path
// and the store write path.
//   funct3   - RV32I load/store width/sign
//   byteOff  - addr[1:0]
//   wordIn   - cached 32-bit word being read
//   storeIn  - low-aligned store data
//   loadOut  - extracted, sign/zero-extended load result
//   storeOut - store data shifted into its byte lanes (other lanes zero)
//   strobe   - byte strobes for the store
module dcache_align
    import dcache_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byteOff,
    input  logic [31:0] wordIn,
    input  logic [31:0] storeIn,
    output logic [31:0] loadOut,
    output logic [31:0] storeOut,
    output logic [3:0]  strobe
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = wordIn[7:0];
        case (byteOff)
            2'd1:    byteSel = wordIn[15:8];
            2'd2:    byteSel = wordIn[23:16];
            2'd3:    byteSel = wordIn[31:24];
            default: byteSel = wordIn[7:0];
        endcase
        // Misaligned halfwords are not trapped; addr[1] alone picks the half.
        halfSel = byteOff[1] ? wordIn[31:16] : wordIn[15:0];

        loadOut = '0;
        case (funct3)
            LB:      loadOut = {{24{byteSel[7]}}, byteSel};
            LH:      loadOut = {{16{halfSel[15]}}, halfSel};
            LW:      loadOut = wordIn;
            LBU:     loadOut = {24'd0, byteSel};
            LHU:     loadOut = {16'd0, halfSel};
            default: loadOut = '0;
        endcase
    end

    always_comb begin
        storeOut = '0;
        strobe   = '0;
        case (funct3)
            SB: begin
                strobe   = 4'b0001 << byteOff;
                storeOut = {24'd0, storeIn[7:0]} << {byteOff, 3'b000};
            end
            SH: begin
                strobe   = byteOff[1] ? 4'b1100 : 4'b0011;
                storeOut = byteOff[1] ? {storeIn[15:0], 16'd0} : {16'd0, storeIn[15:0]};
            end
            SW: begin
                strobe   = 4'b1111;
                storeOut = storeIn;
            end
            default: begin
                strobe   = '0;
                storeOut = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate D-cache for
// the MEM stage. Load hits return data combinationally; load misses stall
// and refill a whole line as a burst; stores always go to memory and stall
// until accepted, merging into the line only when it is already cached.
//   clk, rst            - clock, synchronous active-high reset
//   req_*_i, addr_i,
//   write_data_i        - MEM-stage request (held stable while stall_o)
//   read_data_o         - extended load result (0 unless a load hit)
//   stall_o             - freeze the front of the pipeline this cycle
//   mem_req_*           - backing-memory request handshake
//   mem_addr_o          - word address (writes) / line base (reads)
//   mem_wdata_o/wstrb_o - lane-shifted store data and byte strobes
//   mem_rvalid_i/rdata_i- refill beats, sequential from line base
module data_cache
    import dcache_pkg::*;
#(
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] read_data_o,
    output logic        stall_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic        mem_req_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int OFF_W    = offsetBits(WORDS_PER_LINE);
    localparam int IDX_W    = indexBits(SETS);
    localparam int TAG_W    = tagBits(SETS, WORDS_PER_LINE);
    localparam int LINE_LSB = OFF_W + 2;

    logic [OFF_W-1:0] wordSel;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;

    assign wordSel = addr_i[2 +: OFF_W];
    assign idx     = addr_i[LINE_LSB +: IDX_W];
    assign tag     = addr_i[31 -: TAG_W];

    logic [SETS-1:0]  validArr;
    logic [TAG_W-1:0] tagArr  [SETS];
    logic [31:0]      dataArr [SETS][WORDS_PER_LINE];

    state_t           state, stateNext;
    logic [OFF_W-1:0] beatCnt;

    logic        hit, isLoad, isStore, storeAccept, refillAccept, beatIn, lastBeat;
    logic [31:0] loadWord, storeWord;
    logic [3:0]  storeStrb;

    assign hit          = validArr[idx] && (tagArr[idx] == tag);
    assign isLoad       = req_valid_i && !req_write_i;
    assign isStore      = req_valid_i && req_write_i;
    assign storeAccept  = (state == IDLE) && isStore && mem_req_ready_i;
    assign refillAccept = (state == REFILL_REQ) && mem_req_ready_i;
    // Beats outside REFILL_WAIT (including one coincident with accept) are dropped.
    assign beatIn       = (state == REFILL_WAIT) && mem_rvalid_i;
    assign lastBeat     = (beatCnt == OFF_W'(WORDS_PER_LINE - 1));

    dcache_align uAlign (
        .funct3   (funct3_i),
        .byteOff  (addr_i[1:0]),
        .wordIn   (dataArr[idx][wordSel]),
        .storeIn  (write_data_i),
        .loadOut  (loadWord),
        .storeOut (storeWord),
        .strobe   (storeStrb)
    );

    assign mem_wdata_o = storeWord;
    assign mem_wstrb_o = storeStrb;

    always_comb begin
        stateNext       = state;
        stall_o         = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_write_o = 1'b0;
        mem_addr_o      = '0;
        read_data_o     = '0;
        case (state)
            IDLE: begin
                if (isLoad) begin
                    if (hit) begin
                        read_data_o = loadWord;
                    end else begin
                        stall_o   = 1'b1;
                        stateNext = REFILL_REQ;
                    end
                end else if (isStore) begin
                    mem_req_valid_o = 1'b1;
                    mem_req_write_o = 1'b1;
                    mem_addr_o      = {addr_i[31:2], 2'b00};
                    stall_o         = !mem_req_ready_i;
                end
            end
            REFILL_REQ: begin
                stall_o         = 1'b1;
                mem_req_valid_o = 1'b1;
                mem_addr_o      = {addr_i[31:LINE_LSB], {LINE_LSB{1'b0}}};
                if (mem_req_ready_i) stateNext = REFILL_WAIT;
            end
            REFILL_WAIT: begin
                stall_o = 1'b1;
                if (mem_rvalid_i && lastBeat) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            beatCnt <= '0;
        end else begin
            state <= stateNext;
            if (refillAccept)
                beatCnt <= '0;
            else if (beatIn)
                beatCnt <= beatCnt + OFF_W'(1);
        end
    end

    // The line being refilled is invalidated at accept so a partially
    // overwritten line never hits under its old tag.
    always_ff @(posedge clk) begin
        if (rst)
            validArr <= '0;
        else if (refillAccept)
            validArr[idx] <= 1'b0;
        else if (beatIn && lastBeat)
            validArr[idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (beatIn) begin
            dataArr[idx][beatCnt] <= mem_rdata_i;
            if (lastBeat) tagArr[idx] <= tag;
        end else if (storeAccept && hit) begin
            for (int b = 0; b < 4; b++)
                if (storeStrb[b]) dataArr[idx][wordSel][8*b +: 8] <= storeWord[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_write_i;
    logic [31:0] addr_i, write_data_i;
    logic [2:0]  funct3_i;
    logic [31:0] read_data_o;
    logic        stall_o;
    logic        mem_req_valid_o, mem_req_ready_i, mem_req_write_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    data_cache dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i),
        .addr_i(addr_i), .write_data_i(write_data_i), .funct3_i(funct3_i),
        .read_data_o(read_data_o), .stall_o(stall_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_write_o(mem_req_write_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic [31:0] loadQ[$];
    wr_t         writeQ[$];
    logic [31:0] refMem [logic [31:0]];   // model's view of memory
    logic [31:0] devMem [logic [31:0]];   // backing memory device
    logic [21:0] cTag   [int];            // model: which line each set holds
    int  checks = 0, errors = 0, writeCount = 0;
    int  readyDelay = 0;
    bit  gapPat[$];
    bit  started = 0;

    function automatic logic [31:0] initWord(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'hC3A50F17;
    endfunction

    function automatic logic [31:0] refGet(input logic [31:0] wa);
        if (refMem.exists(wa)) return refMem[wa];
        return initWord(wa);
    endfunction

    function automatic logic [31:0] devGet(input logic [31:0] wa);
        if (devMem.exists(wa)) return devMem[wa];
        return initWord(wa);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] expectLoad(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w, b, h;
        w = refGet({a[31:2], 2'b00});
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return b[7]  ? (b | 32'hFFFFFF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
            3'b010:  return w;
            3'b100:  return b;
            3'b101:  return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit modelHit(input logic [31:0] a);
        int i = int'((a >> 4) & 32'h3F);
        return cTag.exists(i) && (cTag[i] == a[31:10]);
    endfunction

    // Cycles needed to collect four beats under the current gap pattern.
    function automatic int beatCycles();
        int ones = 0, cyc = 0;
        bit g;
        while (ones < 4) begin
            g = (cyc < gapPat.size()) ? gapPat[cyc] : 1'b1;
            cyc++;
            if (g) ones++;
        end
        return cyc;
    endfunction

    task automatic modelStore(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        wr_t e;
        logic [31:0] w;
        e.addr = {a[31:2], 2'b00};
        case (f3)
            3'b000:  begin e.strb = 4'b0001 << a[1:0]; e.data = (d & 32'hFF) << (8 * a[1:0]); end
            3'b001:  begin e.strb = a[1] ? 4'b1100 : 4'b0011; e.data = (d & 32'hFFFF) << (16 * a[1]); end
            default: begin e.strb = 4'b1111; e.data = d; end
        endcase
        writeQ.push_back(e);
        w = refGet(e.addr);
        for (int i = 0; i < 4; i++)
            if (e.strb[i]) w[8*i +: 8] = e.data[8*i +: 8];
        refMem[e.addr] = w;
    endtask

    // ---------------- backing memory ----------------
    bit          refilling = 0;
    int          beat = 0, waitCnt = 0;
    logic [31:0] lineBase = 0;
    logic [31:0] mw;
    bit          gbit;

    initial begin
        mem_req_ready_i = 1'b0;
        mem_rvalid_i    = 1'b0;
        mem_rdata_i     = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            mem_rvalid_i    = 1'b0;
            mem_req_ready_i = 1'b0;
            mem_rdata_i     = 32'd0;
            if (refilling) begin
                gbit = (gapPat.size() > 0) ? gapPat.pop_front() : 1'b1;
                if (gbit) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = devGet(lineBase + 32'(4 * beat));
                    beat++;
                    if (beat == 4) begin refilling = 0; gapPat.delete(); end
                end
            end
            if (rst) begin
                refilling = 0;
                waitCnt   = 0;
                gapPat.delete();
            end else if (mem_req_valid_o) begin
                if (waitCnt < readyDelay) waitCnt++;
                else begin
                    mem_req_ready_i = 1'b1;
                    waitCnt = 0;
                    if (mem_req_write_o) begin
                        mw = devGet(mem_addr_o);
                        for (int i = 0; i < 4; i++)
                            if (mem_wstrb_o[i]) mw[8*i +: 8] = mem_wdata_o[8*i +: 8];
                        devMem[mem_addr_o] = mw;
                    end else begin
                        refilling = 1;
                        beat      = 0;
                        lineBase  = mem_addr_o;
                    end
                end
            end else waitCnt = 0;
        end
    end

    // ---------------- monitor ----------------
    wr_t monW;
    always @(negedge clk) begin
        #2;
        if (started && !rst) begin
            if (req_valid_i && !req_write_i && !stall_o) begin
                if (loadQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_load: got %h with nothing expected", read_data_o);
                end else chk("load_data", read_data_o, loadQ.pop_front());
            end else chk("rdata_zero", read_data_o, 32'd0);
            if (mem_req_valid_o && mem_req_write_o && mem_req_ready_i) begin
                writeCount++;
                if (writeQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %h with nothing expected", mem_addr_o);
                end else begin
                    monW = writeQ.pop_front();
                    chk("wr_addr", mem_addr_o, monW.addr);
                    chk("wr_data", mem_wdata_o, monW.data);
                    chk("wr_strb", {28'd0, mem_wstrb_o}, {28'd0, monW.strb});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic waitDone(input string nm, input int expStall);
        int  n = 0;
        bit  done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            #3;
            if (!stall_o) done = 1;
            else begin n++; @(negedge clk); end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got stall after %0d cycles expected %0d", nm, n, expStall);
        end else chk({nm, "_stall"}, n, expStall);
    endtask

    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3, input string nm);
        int expStall;
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_write_i  = wr;
        addr_i       = a;
        write_data_i = d;
        funct3_i     = f3;
        if (wr) begin
            modelStore(a, d, f3);
            expStall = readyDelay;
        end else begin
            loadQ.push_back(expectLoad(f3, a));
            if (modelHit(a)) expStall = 0;
            else begin
                expStall = 2 + readyDelay + beatCycles();
                cTag[int'((a >> 4) & 32'h3F)] = a[31:10];
            end
        end
        waitDone(nm, expStall);
    endtask

    logic [2:0] ldF3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    int wc0;

    initial begin
        rst = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0;
        addr_i = 32'd0; write_data_i = 32'd0; funct3_i = 3'd0;
        for (int i = 0; i < 4; i++) begin
            refMem[32'h100 + 32'(4 * i)] = 32'h11111111 * (i + 1);
            devMem[32'h100 + 32'(4 * i)] = 32'h11111111 * (i + 1);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        started = 1;
        #3;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_memreq", {31'd0, mem_req_valid_o}, 32'd0);
        chk("rst_rdata", read_data_o, 32'd0);

        // cold miss then hits in the same line
        issue(0, 32'h100, 0, 3'b010, "lw100");
        issue(0, 32'h10C, 0, 3'b010, "lw10C");
        issue(0, 32'h104, 0, 3'b010, "lw104");

        // store hit, then extraction widths
        issue(1, 32'h100, 32'h80FF7F01, 3'b010, "sw100");
        issue(0, 32'h101, 0, 3'b000, "lb101");
        issue(0, 32'h102, 0, 3'b000, "lb102");
        issue(0, 32'h103, 0, 3'b100, "lbu103");
        issue(0, 32'h102, 0, 3'b001, "lh102");
        issue(0, 32'h100, 0, 3'b101, "lhu100");

        // sb with memory slow to accept
        readyDelay = 2;
        issue(1, 32'h101, 32'hFFFFFFAB, 3'b000, "sb101");
        readyDelay = 0;
        issue(0, 32'h100, 0, 3'b010, "lw100b");

        // store miss does not allocate
        wc0 = writeCount;
        issue(1, 32'h2000, 32'hCAFEF00D, 3'b010, "sw2000");
        chk("sw2000_writes", writeCount - wc0, 1);
        issue(0, 32'h2000, 0, 3'b010, "lw2000");

        // gapped refill
        gapPat = '{1, 0, 1, 1, 0, 1};
        issue(0, 32'h400, 0, 3'b010, "lw400gap");
        issue(0, 32'h404, 0, 3'b010, "lw404");
        issue(0, 32'h408, 0, 3'b010, "lw408");
        issue(0, 32'h40C, 0, 3'b010, "lw40C");

        // reset during second refill beat
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = 1'b0; addr_i = 32'h540; funct3_i = 3'b010;
        loadQ.push_back(expectLoad(3'b010, 32'h540));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cTag.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_idle_memreq", {31'd0, mem_req_valid_o}, 32'd0);
        cTag[int'((32'h540 >> 4) & 32'h3F)] = 22'(32'h540 >> 10);
        waitDone("lw540_after_rst", 6);
        issue(0, 32'h54C, 0, 3'b010, "lw54C");
        issue(0, 32'h100, 0, 3'b010, "lw100_after_rst");

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a, d;
            a = 32'($urandom_range(0, 8191));
            d = $urandom;
            readyDelay = $urandom_range(0, 2);
            gapPat.delete();
            for (int k = 0; k < 6; k++) gapPat.push_back($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 6)
                issue(0, a, 0, ldF3[$urandom_range(0, 4)], "rnd_ld");
            else
                issue(1, a, d, 3'($urandom_range(0, 2)), "rnd_st");
        end
        readyDelay = 0;

        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("loadQ_empty", loadQ.size(), 0);
        chk("writeQ_empty", writeQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate data cache that answers the MEM-stage load/store requests of the pipelined core in place of the single-cycle data memory. It sits between the EX/MEM register outputs and a multi-cycle backing memory. It returns hit data in the same cycle, stalls the pipeline on misses and on unaccepted stores, and refills whole lines as a burst.

## Interface
Parameters:
- SETS, 64, number of lines (power of two)
- WORDS_PER_LINE, 4, 32-bit words per line (power of two, ≥2)

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  MEM stage has a load or store
- req_write_i  in  1  1 = store, 0 = load
- addr_i  in  32  byte address (ALUResultM)
- write_data_i  in  32  store data, low-aligned (WriteDataM)
- funct3_i  in  3  RV32I load/store width and sign
- read_data_o  out  32  extended load result
- stall_o  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- mem_req_valid_o  out  1  backing-memory request
- mem_req_ready_i  in  1  request accepted this cycle
- mem_req_write_o  out  1  1 = word write, 0 = line read
- mem_addr_o  out  32  word address for writes; line base for reads
- mem_wdata_o  out  32  lane-shifted store data
- mem_wstrb_o  out  4  byte strobes
- mem_rvalid_i  in  1  refill beat valid
- mem_rdata_i  in  32  refill beat, sequential from line base

## Operation
- Address split: [1:0] byte, next log2(WORDS_PER_LINE) bits word, next log2(SETS) bits index, remainder tag.
- Hit: valid[index] && tag match.
- Loads (funct3): 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Byte lane comes from addr[1:0]; halfword lane from addr[1]; lw ignores addr[1:0].
  - Misaligned accesses are not trapped.
- Stores (funct3): 000 sb, 001 sh, 010 sw. Strobe patterns:
  - sb: 0001 shifted by addr[1:0]
  - sh: 0011 or 1100 (by addr[1])
  - sw: 1111
- FSM states: IDLE, REFILL_REQ, REFILL_WAIT.
- IDLE, load hit: read_data_o valid combinationally; stall_o=0.
- IDLE, load miss: stall_o=1; go to REFILL_REQ.
- REFILL_REQ:
  - Drive mem_req_valid_o=1, mem_req_write_o=0, mem_addr_o = line base (offset bits zero).
  - On mem_req_ready_i: beat counter ← 0; go to REFILL_WAIT.
- REFILL_WAIT:
  - Each mem_rvalid_i writes word[counter]; counter increments.
  - On the beat where counter == WORDS_PER_LINE-1: set tag and valid; go to IDLE.
  - The retried load then hits.
- IDLE, store:
  - Drive mem_req_valid_o=1, mem_req_write_o=1, mem_addr_o = {addr[31:2],2'b00}, plus mem_wdata_o/mem_wstrb_o.
  - stall_o = !mem_req_ready_i.
  - On accept, if hit, merge strobed bytes into the line.
  - A store miss does not allocate.
- read_data_o = 0 unless IDLE && req_valid_i && !req_write_i && hit.
- The requester holds all req_* inputs stable while stall_o=1.
- mem_rvalid_i outside REFILL_WAIT is ignored.

## Timing
- Reset: state IDLE, all valid bits 0, counter 0. While req_valid_i=0, outputs are stall_o=0, mem_req_valid_o=0, read_data_o=0.
- Hit latency is 0 cycles (combinational from addr_i through the tag and data arrays). Arrays are written on the clock edge only.
- Miss penalty, with ready already high and back-to-back beats starting the cycle after accept: stall_o high for exactly 2+WORDS_PER_LINE cycles (6 with defaults).
- Gaps in mem_rvalid_i extend REFILL_WAIT one cycle per gap. A low mem_req_ready_i holds REFILL_REQ.
- Simultaneous mem_rvalid_i and accept in REFILL_REQ: the beat is ignored (memory must not do this).
- Reset mid-refill: IDLE next cycle, all lines invalid, the partial line is discarded, and outstanding beats are ignored.
- Counter wraps at WORDS_PER_LINE-1 only via the REFILL_WAIT→IDLE exit; it is never used in IDLE.

## Structure
- Package dcache_pkg holds:
  - state enum (IDLE, REFILL_REQ, REFILL_WAIT)
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - address field-width functions derived from the parameters
- Sub-module dcache_align: combinational load extract/sign-extend and store lane-shift/strobe generation. It is shared by the read path and the write merge.
- Tag, valid and data arrays are flat registers in data_cache. The valid array must be resettable.

## Test plan
- After reset, lw 0x100 (line memory holds 0x11111111..0x44444444): stall_o high 6 cycles, then read_data_o=0x11111111. A following lw 0x10C hits with 0x44444444 and no stall.
- Cached word 0x80FF7F01 at 0x100: lb 0x101→0x0000007F, lb 0x102→0xFFFFFFFF, lbu 0x103→0x00000080, lh 0x102→0xFFFF80FF, lhu 0x100→0x00007F01.
- sb 0xAB to 0x101 on a hit, with ready held low 2 cycles: stall_o high 2 cycles; mem_wstrb_o=0010, mem_wdata_o=0x0000AB00; then lw 0x100 reads 0x80FFAB01.
- sw to an uncached line 0x2000: one memory write, no refill, valid stays 0; a subsequent lw 0x2000 misses.
- Refill with mem_rvalid_i gapped 1-0-1-1-0-1: four beats land in words 0-3 in order; stall duration 8 cycles.
- rst asserted during the second refill beat: next cycle IDLE; the re-issued lw misses again and fetches a full fresh line.
